// File: rtl/dmd_pattern_sequencer_pkg.sv
// dmd_seq_pkg: shared types and pin encodings for the DMD pattern sequencer.
//   seq_state_t   : sequencer FSM states
//   ROWMD_WRITE   : dmd_rowmd value for a row write strobe
//   BLKMD_GLOBAL  : dmd_blkmd value for a global block reset
package dmd_seq_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ROW, READ, BLK_RST} seq_state_t;

  localparam logic [1:0] ROWMD_WRITE  = 2'b01;
  localparam logic [1:0] BLKMD_GLOBAL = 2'b11;
endpackage

// File: rtl/dmd_pattern_sequencer_if.sv
// dmd_pattern_sequencer_if: row-FIFO bundle between the memory read FIFOs
// and the sequencer.
//   fifo_valid      : per channel, at least one full row buffered
//   fifo_data_valid : per channel read-data valid (one cycle after rd_en)
//   fifo_dout       : read data, channel 0 in the LSBs
//   fifo_rd_en      : shared read enable from the sequencer
// master = FIFO side, slave = sequencer side.
interface dmd_pattern_sequencer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 128
);
  logic [NUM_CH-1:0]        fifo_valid;
  logic [NUM_CH-1:0]        fifo_data_valid;
  logic [NUM_CH*DATA_W-1:0] fifo_dout;
  logic                     fifo_rd_en;

  modport master (output fifo_valid, fifo_data_valid, fifo_dout, input fifo_rd_en);
  modport slave  (input fifo_valid, fifo_data_valid, fifo_dout, output fifo_rd_en);
endinterface

// File: rtl/dmd_pattern_sequencer_row_reader.sv
// dmd_seq_row_reader: reads one row of WORDS_PER_ROW words while rd_act is
// high and aligns the 1-cycle-latency FIFO data onto the DMD pins.
//   rd_act          : FSM is in READ
//   row_addr        : DMD row address of the row being read
//   fifo_rd_en      : shared FIFO read enable (== rd_act)
//   rd_last         : this rd_en is the last word of the row
//   dmd_dout/dvalid : word output, two cycles after its rd_en
//   dmd_rowmd/rowad : row strobe, together with the last word of the row
//   underrun        : sticky, read data was due but not valid on all channels
module dmd_seq_row_reader import dmd_seq_pkg::*; #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 128,
  parameter int WORDS_PER_ROW = 8,
  parameter int ROW_AD_W      = 11
) (
  input  logic                     clk_g,
  input  logic                     rst,
  input  logic                     rd_act,
  input  logic [ROW_AD_W-1:0]      row_addr,
  input  logic [NUM_CH-1:0]        fifo_data_valid,
  input  logic [NUM_CH*DATA_W-1:0] fifo_dout,
  output logic                     fifo_rd_en,
  output logic                     rd_last,
  output logic [NUM_CH*DATA_W-1:0] dmd_dout,
  output logic                     dmd_dvalid,
  output logic [1:0]               dmd_rowmd,
  output logic [ROW_AD_W-1:0]      dmd_rowad,
  output logic                     underrun
);
  localparam int WC_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

  logic [WC_W-1:0]     wcnt;
  logic                due_q;   // FIFO read data is due this cycle
  logic                last_q;  // due word is the last of its row
  logic [ROW_AD_W-1:0] row_q;   // row address travelling with the last word

  assign fifo_rd_en = rd_act;
  assign rd_last    = rd_act && (wcnt == WC_W'(WORDS_PER_ROW - 1));

  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      wcnt       <= '0;
      due_q      <= 1'b0;
      last_q     <= 1'b0;
      row_q      <= '0;
      dmd_dout   <= '0;
      dmd_dvalid <= 1'b0;
      dmd_rowmd  <= 2'b00;
      dmd_rowad  <= '0;
      underrun   <= 1'b0;
    end else begin
      if (rd_act) wcnt <= rd_last ? '0 : wcnt + 1'b1;
      due_q  <= rd_act;
      last_q <= rd_last;
      if (rd_last) row_q <= row_addr;
      // An invalid word is still pushed out (without dvalid) so the row
      // keeps its length and the strobe timing is unaffected.
      if (due_q) dmd_dout <= fifo_dout;
      dmd_dvalid <= due_q && (&fifo_data_valid);
      if (due_q && !(&fifo_data_valid)) underrun <= 1'b1;
      dmd_rowmd <= last_q ? ROWMD_WRITE : 2'b00;
      if (last_q) dmd_rowad <= row_q;
    end
  end
endmodule

// File: rtl/dmd_pattern_sequencer.sv
// dmd_pattern_sequencer: on each accepted trigger, streams 1..15 patterns of
// NUM_ROWS rows from NUM_CH row FIFOs onto the DMD bus, issuing a global
// block reset after every pattern.
//   clk_g, rst        : clock, async active-high reset
//   trigger           : rising-edge sequence trigger (ignored unless
//                       mem_preload_done)
//   seq_len           : patterns per trigger, 0 means 1
//   fifo              : row-FIFO bundle (slave side)
//   dmd_*             : DMD pin interface
//   busy, seq_done    : status; seq_done pulses in the last busy cycle
//   trig_overrun      : sticky, edge while busy; cleared on acceptance
//   underrun          : sticky, read data not valid when due
// Optional: DMD_SEQ_NS_FLIP_EN adds input ns_flip (sampled at acceptance);
// when set, row addresses run NUM_ROWS-1 down to 0.
module dmd_pattern_sequencer import dmd_seq_pkg::*; #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 128,
  parameter int NUM_ROWS      = 1080,
  parameter int WORDS_PER_ROW = 8,
  parameter int ROW_AD_W      = 11,
  parameter int RST_HOLD_CYC  = 16
) (
  input  logic                     clk_g,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic                     mem_preload_done,
  input  logic [3:0]               seq_len,
`ifdef DMD_SEQ_NS_FLIP_EN
  input  logic                     ns_flip,
`endif
  dmd_pattern_sequencer_if.slave   fifo,
  output logic [NUM_CH*DATA_W-1:0] dmd_dout,
  output logic                     dmd_dvalid,
  output logic [1:0]               dmd_rowmd,
  output logic [ROW_AD_W-1:0]      dmd_rowad,
  output logic [1:0]               dmd_blkmd,
  output logic [3:0]               dmd_blkad,
  output logic                     busy,
  output logic                     seq_done,
  output logic                     trig_overrun,
  output logic                     underrun
);
  localparam int HC_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;

  seq_state_t          state;
  logic                trigger_q;
  logic [3:0]          len_q;
  logic [3:0]          pat_cnt;
  logic [ROW_AD_W-1:0] row_cnt;
  logic [HC_W-1:0]     hold_cnt;
  logic                flip_q;
  logic                trig_edge, row_last, hold_last, pat_last, rd_last;
  logic [ROW_AD_W-1:0] row_addr;

  assign trig_edge = trigger & ~trigger_q;
  assign row_last  = (row_cnt == ROW_AD_W'(NUM_ROWS - 1));
  assign hold_last = (hold_cnt == HC_W'(RST_HOLD_CYC - 1));
  assign pat_last  = ((pat_cnt + 4'd1) == len_q);
  assign busy      = (state != IDLE);
  assign seq_done  = (state == BLK_RST) && hold_last && pat_last;
  assign dmd_blkad = 4'd0;
  assign row_addr  = flip_q ? (ROW_AD_W'(NUM_ROWS - 1) - row_cnt) : row_cnt;

`ifndef DMD_SEQ_NS_FLIP_EN
  assign flip_q = 1'b0;
`endif

  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      trigger_q    <= 1'b0;
      len_q        <= '0;
      pat_cnt      <= '0;
      row_cnt      <= '0;
      hold_cnt     <= '0;
      trig_overrun <= 1'b0;
      dmd_blkmd    <= 2'b00;
`ifdef DMD_SEQ_NS_FLIP_EN
      flip_q       <= 1'b0;
`endif
    end else begin
      trigger_q <= trigger;
      // Delayed one cycle so the reset pulse starts with the final word and
      // row strobe of the pattern, never ahead of them.
      dmd_blkmd <= (state == BLK_RST) ? BLKMD_GLOBAL : 2'b00;
      if (trig_edge && busy) trig_overrun <= 1'b1;
      unique case (state)
        IDLE: if (trig_edge && mem_preload_done) begin
          state        <= WAIT_ROW;
          len_q        <= (seq_len == 4'd0) ? 4'd1 : seq_len;
          row_cnt      <= '0;
          pat_cnt      <= '0;
          hold_cnt     <= '0;
          trig_overrun <= 1'b0;
`ifdef DMD_SEQ_NS_FLIP_EN
          flip_q       <= ns_flip;
`endif
        end
        WAIT_ROW: if (&fifo.fifo_valid) state <= READ;
        READ: if (rd_last) begin
          if (row_last) state <= BLK_RST;
          else begin
            state   <= WAIT_ROW;
            row_cnt <= row_cnt + 1'b1;
          end
        end
        BLK_RST: if (hold_last) begin
          hold_cnt <= '0;
          pat_cnt  <= pat_cnt + 4'd1;
          if (pat_last) state <= IDLE;
          else begin
            state   <= WAIT_ROW;
            row_cnt <= '0;
          end
        end else hold_cnt <= hold_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  dmd_seq_row_reader #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W),
    .WORDS_PER_ROW(WORDS_PER_ROW), .ROW_AD_W(ROW_AD_W)
  ) u_rd (
    .clk_g          (clk_g),
    .rst            (rst),
    .rd_act         (state == READ),
    .row_addr       (row_addr),
    .fifo_data_valid(fifo.fifo_data_valid),
    .fifo_dout      (fifo.fifo_dout),
    .fifo_rd_en     (fifo.fifo_rd_en),
    .rd_last        (rd_last),
    .dmd_dout       (dmd_dout),
    .dmd_dvalid     (dmd_dvalid),
    .dmd_rowmd      (dmd_rowmd),
    .dmd_rowad      (dmd_rowad),
    .underrun       (underrun)
  );
endmodule
